// File: rtl/led_stretch_pwm_driver_pkg.sv
// Shared constants and sizing helpers for the LED stretch/PWM driver.
package led_drv_pkg;

    localparam int LED_WIDTH = 5;
    localparam int CLK_HZ    = 50_000_000;

    // Countdown register width able to hold n; never narrower than one bit.
    function automatic int stretch_cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/led_stretch_pwm_driver_if.sv
// Pattern/duty/enable inputs and LED/debug outputs of the stretch/PWM driver.
interface led_stretch_pwm_driver_if #(
    parameter int WIDTH    = 5,
    parameter int PWM_BITS = 8
);
    logic [WIDTH-1:0]    pattern_in;
    logic [PWM_BITS-1:0] duty;
    logic                enable;
    logic [WIDTH-1:0]    led_out;
    logic [WIDTH-1:0]    active;
    logic                frame_start;

    modport master (
        output pattern_in, duty, enable,
        input  led_out, active, frame_start
    );

    modport slave (
        input  pattern_in, duty, enable,
        output led_out, active, frame_start
    );
endinterface

// File: rtl/led_stretch_pwm_driver_stretch_cell.sv
// One LED bit: registered pattern bit plus countdown that holds it on after it falls.
// Latency 1 cycle input->active; no backpressure.
module led_stretch_cell
    import led_drv_pkg::*;
#(
    parameter int STRETCH_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pattern,
    output logic o_active
);
    localparam int            CW   = stretch_cnt_width(STRETCH_CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(STRETCH_CYCLES);

    logic          r_pattern_q;
    logic [CW-1:0] r_cnt;

    // A high bit keeps reloading, so a re-rise mid-countdown never leaves a gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern_q <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_pattern_q <= i_pattern;
            if (r_pattern_q) begin
                r_cnt <= LOAD;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_active = r_pattern_q | (r_cnt != '0);

endmodule

// File: rtl/led_stretch_pwm_driver.sv
// Stretches each PIO LED bit to a minimum on-time, then dims all bits with a frame-aligned PWM.
// Latency 2 cycles pattern_in->led_out; no backpressure, a new pattern is taken every cycle.
module led_stretch_pwm_driver
    import led_drv_pkg::*;
#(
    parameter int WIDTH          = LED_WIDTH,
    parameter int STRETCH_CYCLES = 2_500_000,
    parameter int PWM_BITS       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    led_stretch_pwm_driver_if.slave bus
);
    logic [WIDTH-1:0]    w_active;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty_q;
    logic [WIDTH-1:0]    r_led_out;
    logic                r_frame_start;
    logic                w_wrap;
    logic                w_gate;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        led_stretch_cell #(
            .STRETCH_CYCLES(STRETCH_CYCLES)
        ) u_cell (
            .clk       (clk),
            .rst       (reset),
            .i_pattern (bus.pattern_in[g]),
            .o_active  (w_active[g])
        );
    end

    assign w_wrap = (r_pwm_cnt == '1);
    // All-ones duty must be fully on, which the compare alone would miss by one cycle.
    assign w_gate = (r_duty_q == '1) | (r_pwm_cnt < r_duty_q);

    // Duty is only sampled on the last frame cycle so a frame never sees two duties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt     <= '0;
            r_duty_q      <= '0;
            r_led_out     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pwm_cnt     <= r_pwm_cnt + 1'b1;
            r_frame_start <= w_wrap;
            if (w_wrap) begin
                r_duty_q <= bus.duty;
            end
            r_led_out <= w_active & {WIDTH{w_gate & bus.enable}};
        end
    end

    assign bus.active      = w_active;
    assign bus.led_out     = r_led_out;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_led_stretch_pwm_driver.sv
// Bench for led_stretch_pwm_driver with STRETCH_CYCLES=4, PWM_BITS=3; reference model works on edge histories.
module tb_led_stretch_pwm_driver;
    localparam int W     = 5;
    localparam int ST    = 4;
    localparam int PB    = 3;
    localparam int FRAME = 1 << PB;
    localparam int HMAX  = 4096;

    logic clk;
    logic reset;

    led_stretch_pwm_driver_if #(.WIDTH(W), .PWM_BITS(PB)) bus ();

    led_stretch_pwm_driver #(
        .WIDTH          (W),
        .STRETCH_CYCLES (ST),
        .PWM_BITS       (PB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input history per edge since reset release (index 1 = first active edge).
    logic [W-1:0]  pat_h  [0:HMAX-1];
    logic [PB-1:0] duty_h [0:HMAX-1];
    logic          en_h   [0:HMAX-1];
    int n;
    int checks;
    int passes;

    // Bit i is lit if it was sampled high at any of the last ST+1 edges.
    function automatic logic [W-1:0] m_active(input int k);
        logic [W-1:0] a;
        a = '0;
        for (int i = 0; i < W; i++)
            for (int m = k; m >= 1 && m >= k - ST; m--)
                if (pat_h[m][i]) a[i] = 1'b1;
        return a;
    endfunction

    // Duty in force after edge k: the value sampled at the last frame-ending edge.
    function automatic int m_duty_q(input int k);
        int m;
        m = (k / FRAME) * FRAME;
        return (m >= FRAME) ? int'(duty_h[m]) : 0;
    endfunction

    function automatic logic m_gate(input int k);
        int dq;
        dq = m_duty_q(k);
        return (dq == FRAME - 1) || ((k % FRAME) < dq);
    endfunction

    function automatic logic [W-1:0] m_led(input int k);
        if (k == 0) return '0;
        return m_active(k - 1) & {W{m_gate(k - 1) & en_h[k]}};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) begin
            passes++;
        end else begin
            $error("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic step(input logic [W-1:0] p, input logic [PB-1:0] d, input logic e);
        bus.pattern_in = p;
        bus.duty       = d;
        bus.enable     = e;
        @(posedge clk);
        if (n < HMAX - 1) n++;
        pat_h[n]  = p;
        duty_h[n] = d;
        en_h[n]   = e;
        #1;
        check("led_out", 32'(bus.led_out), 32'(m_led(n)));
        check("active", 32'(bus.active), 32'(m_active(n)));
        check("frame_start", 32'(bus.frame_start), 32'((n > 0) && (n % FRAME == 0)));
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_led"}, 32'(bus.led_out), 32'd0);
        check({tag, "_active"}, 32'(bus.active), 32'd0);
        check({tag, "_fs"}, 32'(bus.frame_start), 32'd0);
    endtask

    initial begin
        int run;
        logic [W-1:0] rp;
        logic [PB-1:0] rd;
        checks = 0;
        passes = 0;
        n = 0;
        reset = 1'b1;
        bus.pattern_in = '0;
        bus.duty = '1;
        bus.enable = 1'b1;
        #2;
        check_dark("reset_init");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First frame after release stays dark even with a lit pattern.
        for (int i = 0; i < 10; i++) step(5'h1F, 3'd7, 1'b1);
        for (int i = 0; i < 8; i++) step(5'h00, 3'd7, 1'b1);

        // Single-cycle pulse on bit 0 stays active for 1+ST cycles.
        run = 0;
        step(5'b00001, 3'd7, 1'b1);
        if (bus.active[0]) run++;
        for (int i = 0; i < 8; i++) begin
            step(5'b00000, 3'd7, 1'b1);
            if (bus.active[0]) run++;
        end
        check("stretch_len", 32'(run), 32'(ST + 1));

        // Re-pulse while the countdown sits at 2.
        step(5'b00001, 3'd7, 1'b1);
        for (int i = 0; i < 2; i++) step(5'b00000, 3'd7, 1'b1);
        step(5'b00001, 3'd7, 1'b1);
        for (int i = 0; i < 8; i++) step(5'b00000, 3'd7, 1'b1);

        // PWM at duty 3, 0 and 7.
        for (int i = 0; i < 24; i++) step(5'h1F, 3'd3, 1'b1);
        for (int i = 0; i < 16; i++) step(5'h1F, 3'd0, 1'b1);
        for (int i = 0; i < 16; i++) step(5'h1F, 3'd7, 1'b1);

        // Duty 2 settles, then a change to 6 lands mid-frame.
        while ((n % FRAME) != 0) step(5'h1F, 3'd2, 1'b1);
        for (int i = 0; i < 9; i++) step(5'h1F, 3'd2, 1'b1);
        for (int i = 0; i < 24; i++) step(5'h1F, 3'd6, 1'b1);

        // Enable drops for three edges.
        for (int i = 0; i < 4; i++) step(5'b10101, 3'd7, 1'b1);
        for (int i = 0; i < 3; i++) step(5'b10101, 3'd7, 1'b0);
        for (int i = 0; i < 3; i++) step(5'b10101, 3'd7, 1'b1);

        // Bits 4 and 0 toggled at staggered times.
        step(5'b10000, 3'd7, 1'b1);
        step(5'b00000, 3'd7, 1'b1);
        step(5'b00001, 3'd7, 1'b1);
        step(5'b00000, 3'd7, 1'b1);
        step(5'b10000, 3'd7, 1'b1);
        for (int i = 0; i < 3; i++) step(5'b00000, 3'd7, 1'b1);
        step(5'b00001, 3'd7, 1'b1);
        for (int i = 0; i < 8; i++) step(5'b00000, 3'd7, 1'b1);

        // Randomised traffic.
        rd = 3'd5;
        for (int i = 0; i < 400; i++) begin
            rp = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 9) == 0) rd = PB'($urandom);
            step(rp, rd, ($urandom_range(0, 7) != 0));
        end

        // Mid-run asynchronous reset.
        for (int i = 0; i < 20; i++) step(5'h1F, 3'd7, 1'b1);
        check("pre_reset_led", 32'(bus.led_out), 32'h1F);
        #2;
        reset = 1'b1;
        #1;
        check_dark("reset_async");
        @(posedge clk);
        #1;
        check_dark("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < HMAX; i++) begin
            pat_h[i]  = '0;
            duty_h[i] = '0;
            en_h[i]   = 1'b0;
        end
        for (int i = 0; i < 20; i++) step(5'h1F, 3'd4, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
